// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [2*OPW-1:0]   req_op,
    output logic [1:0]         req_ready,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [OPW-1:0]     alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_flag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_flag,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa_p0;
    logic [WIDTH-1:0] opb_p0;
    logic [OPW-1:0]   opc_p0;
    logic             id_p0;
    logic [1:0]       grant;
    logic             win_id;
    logic             handshake;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 2'b00;
        if (req_valid[0])
            grant = 2'b01;
        else if (req_valid[1])
            grant = 2'b10;
    end
`else
    logic last_grant;

    // On a tie, the requester that did not win last time is served.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
`endif

    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign handshake = |req_ready;
    assign win_id    = req_ready[1];

    assign alu_a  = opa_p0;
    assign alu_b  = opb_p0;
    assign alu_op = opc_p0;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            opa_p0     <= '0;
            opb_p0     <= '0;
            opc_p0     <= '0;
            id_p0      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flag   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                // Operand stage: capture the winner's request
                IDLE: begin
                    if (handshake) begin
                        opa_p0 <= req_a[win_id*WIDTH +: WIDTH];
                        opb_p0 <= req_b[win_id*WIDTH +: WIDTH];
                        opc_p0 <= req_op[win_id*OPW +: OPW];
                        id_p0  <= win_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= win_id;
`endif
                        state  <= EXEC;
                    end
                end
                // Result stage: sample the shared ALU
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flag   <= alu_flag;
                    rsp_id     <= id_p0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small stand-in ALU (add/sub/and/xor, zero flag).
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         req_valid;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [2*OPW-1:0]   req_op;
    logic [1:0]         req_ready;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [OPW-1:0]     alu_op;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_flag;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_flag;
    logic               busy;

    int n_run  = 0;
    int n_fail = 0;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_flag   (alu_flag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'h0:    alu_result = alu_a + alu_b;
            4'h1:    alu_result = alu_a - alu_b;
            4'h2:    alu_result = alu_a & alu_b;
            4'h3:    alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_flag = (alu_result == '0);
    end

    typedef struct {
        string       name;
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  op0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  op1;
        logic [1:0]  exp_ready;
        logic [31:0] exp_res;
        logic        exp_flag;
    } vec_t;

    vec_t       vecs[6];
    logic [1:0] exp_tie[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op0, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [3:0] op1);
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_op    = {op1, op0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        int cyc;
        logic [31:0] wa;

        vecs[0] = '{"single_r0", 2'b01, 32'd5, 32'd3, 4'h0, 32'd0, 32'd0, 4'h0, 2'b01, 32'd8, 1'b0};
`ifdef ALU_ARB_FIXED_PRIO_EN
        vecs[1] = '{"tie_a", 2'b11, 32'd1, 32'd1, 4'h0, 32'd10, 32'd4, 4'h1, 2'b01, 32'd2, 1'b0};
        vecs[5] = '{"tie_c", 2'b11, 32'd2, 32'd2, 4'h0, 32'd9, 32'd4, 4'h1, 2'b01, 32'd4, 1'b0};
        exp_tie = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        vecs[1] = '{"tie_a", 2'b11, 32'd1, 32'd1, 4'h0, 32'd10, 32'd4, 4'h1, 2'b10, 32'd6, 1'b0};
        vecs[5] = '{"tie_c", 2'b11, 32'd2, 32'd2, 4'h0, 32'd9, 32'd4, 4'h1, 2'b10, 32'd5, 1'b0};
        exp_tie = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        vecs[2] = '{"zero_flag", 2'b11, 32'hFFFFFFFF, 32'd1, 4'h0, 32'd7, 32'd7, 4'h1, 2'b01, 32'd0, 1'b1};
        vecs[3] = '{"single_r1", 2'b10, 32'd0, 32'd0, 4'h0, 32'h0000F0F0, 32'h00000FF0, 4'h2, 2'b10, 32'h000000F0, 1'b0};
        vecs[4] = '{"tie_b_xor", 2'b11, 32'd3, 32'd3, 4'h3, 32'd1, 32'd1, 4'h0, 2'b01, 32'd0, 1'b1};

        reset     = 1'b1;
        rsp_ready = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_flag", rsp_flag, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Tie right after reset, responses always accepted
        drive(2'b11, 32'd2, 32'd2, 4'h0, 32'd3, 32'd3, 4'h0);
        rsp_ready = 1'b1;
        ng  = 0;
        cyc = 0;
        while (ng < 4 && cyc < 60) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                check("tie_grant", req_ready, exp_tie[ng]);
                ng++;
            end
            cyc++;
        end
        if (ng < 4) check("tie_timeout", ng, 4);
        @(posedge clk);
        #1 req_valid = 2'b00;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("tie_drain_busy", busy, 0);
        rsp_ready = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].op0,
                  vecs[i].a1, vecs[i].b1, vecs[i].op1);
            wa = vecs[i].exp_ready[1] ? vecs[i].a1 : vecs[i].a0;
            @(negedge clk);
            check({vecs[i].name, "_ready"}, req_ready, vecs[i].exp_ready);
            check({vecs[i].name, "_idle_busy"}, busy, 0);
            @(posedge clk);
            #1 req_valid = 2'b00;
            @(negedge clk);
            check({vecs[i].name, "_exec_busy"}, busy, 1);
            check({vecs[i].name, "_exec_ready"}, req_ready, 0);
            check({vecs[i].name, "_exec_alu_a"}, alu_a, wa);
            check({vecs[i].name, "_exec_rsp_valid"}, rsp_valid, 0);
            @(posedge clk);
            @(negedge clk);
            check({vecs[i].name, "_rsp_valid"}, rsp_valid, 1);
            check({vecs[i].name, "_rsp_id"}, rsp_id, vecs[i].exp_ready[1]);
            check({vecs[i].name, "_rsp_result"}, rsp_result, vecs[i].exp_res);
            check({vecs[i].name, "_rsp_flag"}, rsp_flag, vecs[i].exp_flag);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            @(negedge clk);
            check({vecs[i].name, "_done_valid"}, rsp_valid, 0);
            check({vecs[i].name, "_done_busy"}, busy, 0);
            @(posedge clk);
            #1;
        end

        // Backpressure in RESP with requester 1 waiting
        drive(2'b01, 32'd20, 32'd22, 4'h0, 32'd100, 32'd1, 4'h0);
        @(negedge clk);
        check("bp_grant0", req_ready, 2'b01);
        @(posedge clk);
        #1 req_valid = 2'b10;
        @(negedge clk);
        check("bp_exec_ready", req_ready, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_result", rsp_result, 32'd42);
            check("bp_hold_id", rsp_id, 0);
            check("bp_hold_ready", req_ready, 0);
            check("bp_hold_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", req_ready, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_grant1", req_ready, 2'b10);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check("bp_r1_valid", rsp_valid, 1);
        check("bp_r1_result", rsp_result, 32'd101);
        check("bp_r1_id", rsp_id, 1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Reset asserted while an operation is in EXEC
        drive(2'b01, 32'd77, 32'd1, 4'h0, 32'd0, 32'd0, 4'h0);
        @(negedge clk);
        check("rx_grant", req_ready, 2'b01);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        check("rx_exec_busy", busy, 1);
        check("rx_exec_alu_a", alu_a, 32'd77);
        #2 reset = 1'b1;
        #1;
        check("rx_busy", busy, 0);
        check("rx_alu_a", alu_a, 0);
        check("rx_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rx_no_rsp", rsp_valid, 0);
        end
        @(posedge clk);
        #1 drive(2'b11, 32'd1, 32'd2, 4'h0, 32'd3, 32'd4, 4'h0);
        @(negedge clk);
        check("rx_tie_grant", req_ready, 2'b01);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check("rx_rsp_result", rsp_result, 32'd3);
        check("rx_rsp_id", rsp_id, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
